// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, full-word-write memory between fetch and load/store
// requesters with round-robin arbitration; partial-mask stores become read-modify-write.
//
// state      | meaning
// IDLE       | arbitrate; ready asserted for the granted requester
// I_CMD      | fetch read command presented to memory
// I_WAIT     | waiting for fetch read data
// D_CMD      | load read, full store, or RMW merged write presented to memory
// D_WAIT     | waiting for load data / write ack
// RMW_RD     | RMW read of the target word presented to memory
// RMW_RWAIT  | waiting for RMW read data, then merge
// D_NULL     | all-zero-mask store completes without memory access
module mem_port_arbiter #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_wmask,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    I_CMD,
    I_WAIT,
    D_CMD,
    D_WAIT,
    RMW_RD,
    RMW_RWAIT,
    D_NULL
  } state_e;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0] mask_q, mask_d;
  logic [WORD_LEN-1:0] store_q, store_d;
  logic                is_load_q, is_load_d;
  logic [WORD_LEN-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_LEN-1:0] d_rdata_q, d_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;

  logic grant_i;
  logic grant_d;
  logic mask_full;
  logic mask_none;
  logic cmd_fire;

  // Fetch wins a tie only when data was granted last.
  assign grant_i   = i_req_valid && (!d_req_valid || (last_grant_q == GRANT_DATA));
  assign grant_d   = d_req_valid && !grant_i;
  assign mask_full = &d_wmask;
  assign mask_none = ~|d_wmask;

  assign i_req_ready   = (state_q == IDLE) && grant_i;
  assign d_req_ready   = (state_q == IDLE) && grant_d;
  assign mem_cmd_valid = (state_q == I_CMD) || (state_q == D_CMD) || (state_q == RMW_RD);
  assign cmd_fire      = mem_cmd_valid && mem_cmd_ready;

  assign mem_addr     = addr_q;
  assign mem_wen      = wen_q;
  assign mem_wdata    = wdata_q;
  assign i_resp_valid = i_resp_q;
  assign i_rdata      = i_rdata_q;
  assign d_resp_valid = d_resp_q;
  assign d_rdata      = d_rdata_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    store_d      = store_q;
    is_load_d    = is_load_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          last_grant_d = GRANT_FETCH;
          addr_d       = i_addr;
          wen_d        = 1'b0;
          state_d      = I_CMD;
        end else if (grant_d) begin
          last_grant_d = GRANT_DATA;
          addr_d       = d_addr;
          mask_d       = d_wmask;
          store_d      = d_wdata;
          is_load_d    = !d_wen;
          if (!d_wen) begin
            wen_d   = 1'b0;
            state_d = D_CMD;
          end else if (mask_full) begin
            wen_d   = 1'b1;
            wdata_d = d_wdata;
            state_d = D_CMD;
          end else if (mask_none) begin
            state_d = D_NULL;
          end else begin
            wen_d   = 1'b0;
            state_d = RMW_RD;
          end
        end
      end
      I_CMD: begin
        if (cmd_fire) state_d = I_WAIT;
      end
      I_WAIT: begin
        if (mem_resp_valid) begin
          i_rdata_d = mem_rdata;
          i_resp_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      D_CMD: begin
        if (cmd_fire) state_d = D_WAIT;
      end
      D_WAIT: begin
        if (mem_resp_valid) begin
          if (is_load_q) d_rdata_d = mem_rdata;
          d_resp_d = 1'b1;
          state_d  = IDLE;
        end
      end
      RMW_RD: begin
        if (cmd_fire) state_d = RMW_RWAIT;
      end
      RMW_RWAIT: begin
        // Fetch stays locked out until the merged write completes in D_WAIT.
        if (mem_resp_valid) begin
          wdata_d = (mem_rdata & ~mask_q) | (store_q & mask_q);
          wen_d   = 1'b1;
          state_d = D_CMD;
        end
      end
      D_NULL: begin
        d_resp_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DATA;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      mask_q       <= '0;
      store_q      <= '0;
      is_load_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      store_q      <= store_d;
      is_load_q    <= is_load_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
    end
  end

endmodule
